ram_dp_sync: RTL and testbench

Parametrised synchronous two-port RAM: one write port and one independent registered read port, with a built-in clear engine that zero-fills the whole array after reset or on request. It succeeds the fixed 64x8 RAM as the CPU's general data/register storage. Width and depth are set per instance, and read-during-write ordering is defined.

---
 rtl/ram_dp_sync_pkg.sv | 16 +
 rtl/ram_clear_seq.sv | 63 ++++++
 rtl/ram_dp_sync.sv | 96 +++++++++
 tb/tb_ram_dp_sync.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_sync_pkg.sv
// rtl/ram_dp_sync_pkg.sv - shared constants, state encoding and helpers for ram_dp_sync
package ram_dp_sync_pkg;

    localparam int WORDSIZE = 8;

    typedef enum logic {
        RAM_ST_INIT = 1'b0,
        RAM_ST_RUN  = 1'b1
    } ram_state_t;

    // True when a (zero-extended) address falls inside an array of the given depth.
    function automatic logic addr_ok(input int addr, input int depth);
        return (addr >= 0) && (addr < depth);
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - INIT/RUN engine that zero-fills the array after reset or on request
module ram_clear_seq
    import ram_dp_sync_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clear_req,
    output logic              init_busy,
    output logic              zero_we,
    output logic [ADDR_W-1:0] zero_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state;
    ram_state_t        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= RAM_ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            RAM_ST_INIT: begin
                // The last word is written on this edge; the pointer parks at 0 for the next clear.
                if (ptr == LAST_ADDR) begin
                    state_nxt = RAM_ST_RUN;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            RAM_ST_RUN: begin
                if (clear_req) begin
                    state_nxt = RAM_ST_INIT;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RAM_ST_INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign init_busy = (state == RAM_ST_INIT);
    assign zero_we   = (state == RAM_ST_INIT);
    assign zero_addr = ptr;

endmodule

// File: rtl/ram_dp_sync.sv
// rtl/ram_dp_sync.sv - parametrised write-port/read-port RAM with write-first bypass and clear engine
module ram_dp_sync
    import ram_dp_sync_pkg::*;
#(
    parameter int WIDTH  = WORDSIZE,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              init_busy
);

    logic [WIDTH-1:0]  mem [0:DEPTH-1];

    logic              zero_we;
    logic [ADDR_W-1:0] zero_addr;

    logic              run;
    logic              wr_ok;
    logic              rd_ok;
    logic              user_we;
    logic              rd_fire;
    logic              bypass;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;

    ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .clr_n     (clr_n),
        .clear_req (clear_req),
        .init_busy (init_busy),
        .zero_we   (zero_we),
        .zero_addr (zero_addr)
    );

    // A clear request sampled in RUN pre-empts any user access on the same edge.
    assign run     = !init_busy;
    assign wr_ok   = addr_ok(32'(wr_addr), DEPTH);
    assign rd_ok   = addr_ok(32'(rd_addr), DEPTH);
    assign user_we = run && !clear_req && write_en && wr_ok;
    assign rd_fire = run && !clear_req && rd_en;
    assign bypass  = user_we && (wr_addr == rd_addr);

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (zero_we) begin
            mem_we = 1'b1;
            mem_wa = zero_addr;
        end else if (user_we) begin
            mem_we = 1'b1;
            mem_wa = wr_addr;
            mem_wd = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                if (!rd_ok) begin
                    data_out <= '0;
                end else if (bypass) begin
                    data_out <= data_in;
                end else begin
                    data_out <= mem[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_sync.sv
// tb/tb_ram_dp_sync.sv - directed self-checking bench for ram_dp_sync (64x8 and 40x16 instances)
module tb_ram_dp_sync;

    logic        clk;
    logic        clr_n;

    logic        a_we, a_re, a_clr, a_rv, a_busy;
    logic [5:0]  a_wa, a_ra;
    logic [7:0]  a_wd, a_do;

    logic        b_we, b_re, b_clr, b_rv, b_busy;
    logic [5:0]  b_wa, b_ra;
    logic [15:0] b_wd, b_do;

    int checks = 0;
    int errors = 0;
    int n, na, nb, v;

    logic [7:0] basic_d [4] = '{8'd10, 8'd12, 8'd2, 8'd3};
    logic [5:0] zero_rd [3] = '{6'd0, 6'd31, 6'd63};

    ram_dp_sync u_a (
        .clk       (clk),
        .clr_n     (clr_n),
        .write_en  (a_we),
        .wr_addr   (a_wa),
        .data_in   (a_wd),
        .rd_en     (a_re),
        .rd_addr   (a_ra),
        .data_out  (a_do),
        .rd_valid  (a_rv),
        .clear_req (a_clr),
        .init_busy (a_busy)
    );

    ram_dp_sync #(.WIDTH(16), .DEPTH(40)) u_b (
        .clk       (clk),
        .clr_n     (clr_n),
        .write_en  (b_we),
        .wr_addr   (b_wa),
        .data_in   (b_wd),
        .rd_en     (b_re),
        .rd_addr   (b_ra),
        .data_out  (b_do),
        .rd_valid  (b_rv),
        .clear_req (b_clr),
        .init_busy (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        a_we = 0; a_re = 0; a_clr = 0; a_wa = 0; a_ra = 0; a_wd = 0;
        b_we = 0; b_re = 0; b_clr = 0; b_wa = 0; b_ra = 0; b_wd = 0;
        step();
        step();
        chk("rst_busy_a", 32'(a_busy), 1);
        chk("rst_valid_a", 32'(a_rv), 0);
        chk("rst_dout_a", 32'(a_do), 0);
        chk("rst_busy_b", 32'(b_busy), 1);

        // Power-up zero fill on both instances
        clr_n = 1'b1;
        n = 0; na = 0; nb = 0;
        while ((na == 0 || nb == 0) && n < 200) begin
            step();
            n++;
            if (!a_busy && na == 0) na = n;
            if (!b_busy && nb == 0) nb = n;
        end
        chk("init_len_a", 32'(na), 64);
        chk("init_len_b", 32'(nb), 40);

        a_re = 1;
        for (int i = 0; i < 3; i++) begin
            a_ra = zero_rd[i];
            step();
            chk("init_rd_dout", 32'(a_do), 0);
            chk("init_rd_valid", 32'(a_rv), 1);
        end
        a_re = 0;

        // Basic write then back-to-back reads
        a_we = 1;
        for (int i = 0; i < 4; i++) begin
            a_wa = 6'(i);
            a_wd = basic_d[i];
            step();
        end
        a_we = 0;
        a_re = 1;
        for (int i = 0; i < 4; i++) begin
            a_ra = 6'(i);
            step();
            chk("basic_dout", 32'(a_do), 32'(basic_d[i]));
            chk("basic_valid", 32'(a_rv), 1);
        end
        a_re = 0;
        step();
        chk("idle_valid", 32'(a_rv), 0);
        chk("idle_hold", 32'(a_do), 3);

        // Same-address write-first bypass, then independent addresses
        a_we = 1; a_wa = 7; a_wd = 8'h5A;
        a_re = 1; a_ra = 7;
        step();
        chk("bypass_dout", 32'(a_do), 32'h5A);
        chk("bypass_valid", 32'(a_rv), 1);
        a_wa = 8; a_wd = 8'h11; a_ra = 7;
        step();
        chk("indep_dout", 32'(a_do), 32'h5A);
        a_we = 0; a_ra = 8;
        step();
        chk("indep_rd8", 32'(a_do), 32'h11);

        // Clear request wins over a simultaneous write and read
        a_clr = 1; a_we = 1; a_wa = 4; a_wd = 8'hFF; a_ra = 0;
        step();
        chk("clr_busy", 32'(a_busy), 1);
        chk("clr_valid", 32'(a_rv), 0);
        chk("clr_hold", 32'(a_do), 32'h11);
        a_clr = 0; a_we = 0;
        n = 0; v = 0;
        while (a_busy && n < 200) begin
            step();
            n++;
            if (a_rv) v++;
        end
        chk("clr_len", 32'(n), 64);
        chk("clr_no_valid", 32'(v), 0);
        chk("clr_hold_end", 32'(a_do), 32'h11);
        for (int i = 0; i < 5; i++) begin
            a_ra = 6'(i);
            step();
            chk("clr_rd_zero", 32'(a_do), 0);
            chk("clr_rd_valid", 32'(a_rv), 1);
        end
        a_ra = 7;
        step();
        chk("clr_rd7_zero", 32'(a_do), 0);
        a_re = 0;

        // Non-power-of-two depth: out-of-range write dropped, read returns 0
        b_we = 1; b_wa = 45; b_wd = 16'hBEEF;
        step();
        b_wa = 39;
        step();
        b_we = 0; b_re = 1; b_ra = 45;
        step();
        chk("oor_rd_dout", 32'(b_do), 0);
        chk("oor_rd_valid", 32'(b_rv), 1);
        b_ra = 39;
        step();
        chk("b_rd39", 32'(b_do), 32'hBEEF);
        b_ra = 5;
        step();
        chk("b_rd5_alias", 32'(b_do), 0);
        b_re = 0;

        // Reset mid-INIT restarts the full zero fill
        a_we = 1; a_wa = 10; a_wd = 8'h77;
        step();
        a_we = 0; a_re = 1; a_ra = 10;
        step();
        chk("pre_rst_rd10", 32'(a_do), 32'h77);
        a_re = 0;
        clr_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(a_do), 0);
        chk("async_rst_busy", 32'(a_busy), 1);
        step();
        clr_n = 1'b1;
        repeat (20) step();
        clr_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 1);
        step();
        clr_n = 1'b1;
        a_re = 1; a_ra = 10;
        n = 0; v = 0;
        while (a_busy && n < 200) begin
            step();
            n++;
            if (a_rv) v++;
        end
        chk("mid_rst_len", 32'(n), 64);
        chk("mid_rst_no_valid", 32'(v), 0);
        step();
        chk("mid_rst_rd10", 32'(a_do), 0);
        chk("mid_rst_rd_valid", 32'(a_rv), 1);
        a_re = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
